// File: rtl/avl_sample_fetch.sv
// avl_sample_fetch: fetches a block of 32-bit sample words over an Avalon-MM
// read master and streams them, in address order, through a small
// first-word-fall-through buffer toward an audio sink.
module avl_sample_fetch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_WORD = (AW+1)'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state;
  logic [31:0]   addr;
  logic [15:0]   remaining;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Read strobe, buffer handshakes and status outputs derived from registered state
  always_comb begin
    m_read      = (state == FETCH) && (remaining != 16'd0) && (count < DEPTH);
    push        = m_read && !m_waitrequest;
    out_valid   = (count != '0);
    pop         = out_valid && out_ready;
    out_data    = out_valid ? mem[rd_ptr] : 32'd0;
    m_address   = addr;
    busy        = (state != IDLE);
    m_write     = 1'b0;
    m_writedata = 32'd0;
  end

  // Transfer sequencing: accept a request, walk the address range, wait for the sink to drain
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= 32'd0;
      remaining <= 16'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count != 16'd0) begin
              addr      <= base_addr;
              remaining <= word_count;
              state     <= FETCH;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (push) begin
            addr      <= addr + 32'd4;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && (count == ONE_WORD)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_WORD;
        2'b01:   count <= count - ONE_WORD;
        default: count <= count;
      endcase
    end
  end

  // Buffer storage captures read data in the cycle the read is accepted
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= m_readdata;
    end
  end

endmodule

// File: tb/tb_avl_sample_fetch.sv
// tb_avl_sample_fetch: directed scenarios for avl_sample_fetch with a
// scoreboard of expected read addresses, hold lengths and output words.
module tb_avl_sample_fetch;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  int          exp_hold_q [$];

  int          acc_cnt  = 0;
  int          acc_base = 0;
  int          hold_cnt = 0;
  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr    = 32'd0;

  int   rd_idx    = 0;
  int   stall_cnt = 0;
  logic stall_en  = 1'b0;
  int   stall_at  = 0;
  int   stall_len = 0;

  avl_sample_fetch #(.FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a function of byte address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]};
  endfunction

  assign m_readdata    = mem_word(m_address);
  assign m_waitrequest = stall_en && (rd_idx == stall_at) && (stall_cnt < stall_len);

  // Slave model bookkeeping: counts accepted reads and stalled cycles
  always @(posedge clk) begin
    if (reset && m_read) begin
      if (m_waitrequest) begin
        stall_cnt <= stall_cnt + 1;
      end else begin
        rd_idx    <= rd_idx + 1;
        stall_cnt <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] a, input int hold);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(mem_word(a));
    exp_hold_q.push_back(hold);
  endtask

  // Monitor: compares every accepted read and every delivered word against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      hold_cnt     = 0;
      prev_pending = 1'b0;
    end else begin
      if (m_read) begin
        hold_cnt++;
        if (prev_pending) begin
          checkOutput("addr_held", m_address, prev_addr);
        end
        if (!m_waitrequest) begin
          if (exp_addr_q.size() == 0) begin
            checkOutput("unexpected_read", m_address, 32'hFFFF_FFFF);
          end else begin
            checkOutput("read_addr", m_address, exp_addr_q.pop_front());
            checkOutput("read_hold", 32'(hold_cnt), 32'(exp_hold_q.pop_front()));
          end
          acc_cnt++;
          hold_cnt = 0;
        end
      end
      prev_pending = m_read && m_waitrequest;
      prev_addr    = m_address;
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          checkOutput("unexpected_word", out_data, 32'hFFFF_FFFF);
        end else begin
          checkOutput("out_word", out_data, exp_data_q.pop_front());
        end
      end
    end
  end

  // Pulses start for one cycle and checks the first response one cycle later
  task automatic applyStimulus(input logic [31:0] base, input logic [15:0] wc);
    @(posedge clk);
    #1;
    base_addr  = base;
    word_count = wc;
    start      = 1'b1;
    acc_base   = acc_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    if (wc != 16'd0) begin
      checkOutput("first_read_latency", {31'd0, m_read}, 32'd1);
    end else begin
      checkOutput("zero_done", {31'd0, done}, 32'd1);
      checkOutput("zero_no_read", {31'd0, m_read}, 32'd0);
      @(negedge clk);
      checkOutput("zero_done_single", {31'd0, done}, 32'd0);
      checkOutput("zero_no_read2", {31'd0, m_read}, 32'd0);
      checkOutput("zero_idle", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic wait_done();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("done_seen", {31'd0, found}, 32'd1);
    if (found) begin
      checkOutput("idle_at_done", {31'd0, busy}, 32'd0);
      checkOutput("words_left", 32'(exp_data_q.size()), 32'd0);
      @(negedge clk);
      checkOutput("done_single", {31'd0, done}, 32'd0);
      checkOutput("busy_after", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic check_reset_outputs();
    checkOutput("rst_m_read", {31'd0, m_read}, 32'd0);
    checkOutput("rst_m_address", m_address, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seen_done;
    logic reached;
    reset      = 1'b0;
    start      = 1'b0;
    base_addr  = 32'd0;
    word_count = 16'd0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] basic three-word transfer");
    expect_word(32'h0000_1000, 1);
    expect_word(32'h0000_1004, 1);
    expect_word(32'h0000_1008, 1);
    applyStimulus(32'h0000_1000, 16'd3);
    @(negedge clk);
    checkOutput("valid_latency", {31'd0, out_valid}, 32'd1);
    wait_done();

    $display("[TB] zero-length request");
    applyStimulus(32'h0000_7000, 16'd0);

    $display("[TB] back-pressure with eight words");
    out_ready = 1'b0;
    expect_word(32'h0000_2000, 1);
    expect_word(32'h0000_2004, 1);
    expect_word(32'h0000_2008, 1);
    expect_word(32'h0000_200C, 1);
    expect_word(32'h0000_2010, 1);
    expect_word(32'h0000_2014, 1);
    expect_word(32'h0000_2018, 1);
    expect_word(32'h0000_201C, 1);
    applyStimulus(32'h0000_2000, 16'd8);
    @(posedge clk);
    #1;
    base_addr  = 32'hDEAD_0000;
    word_count = 16'd1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("full_reads", 32'(acc_cnt - acc_base), 32'd4);
    checkOutput("full_m_read", {31'd0, m_read}, 32'd0);
    checkOutput("full_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("full_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    wait_done();

    $display("[TB] wait-request stall on second read");
    stall_en  = 1'b1;
    stall_at  = rd_idx + 1;
    stall_len = 3;
    expect_word(32'h0000_3000, 1);
    expect_word(32'h0000_3004, 4);
    expect_word(32'h0000_3008, 1);
    applyStimulus(32'h0000_3000, 16'd3);
    wait_done();
    stall_en = 1'b0;

    $display("[TB] address wrap");
    expect_word(32'hFFFF_FFF8, 1);
    expect_word(32'hFFFF_FFFC, 1);
    expect_word(32'h0000_0000, 1);
    applyStimulus(32'hFFFF_FFF8, 16'd3);
    wait_done();

    $display("[TB] reset mid-transfer");
    expect_word(32'h0000_4000, 1);
    expect_word(32'h0000_4004, 1);
    expect_word(32'h0000_4008, 1);
    expect_word(32'h0000_400C, 1);
    expect_word(32'h0000_4010, 1);
    applyStimulus(32'h0000_4000, 16'd5);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if ((acc_cnt - acc_base) >= 2) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("two_reads_seen", {31'd0, reached}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_hold_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    seen_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checkOutput("no_done_after_abort", 32'(seen_done), 32'd0);
    checkOutput("idle_after_abort", {31'd0, busy}, 32'd0);

    $display("[TB] fresh transfer after abort");
    expect_word(32'h0000_5000, 1);
    expect_word(32'h0000_5004, 1);
    applyStimulus(32'h0000_5000, 16'd2);
    wait_done();

    repeat (3) @(negedge clk);
    checkOutput("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
